// File: rtl/axil_stream_reader.sv
// axil_stream_reader: reads a block of words over AXI-Lite and replays it as an AXI-Stream.
module axil_stream_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int unsigned CNT_W    = LEN_WIDTH + 1;
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned ADDR_LSB = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q, state_n;
  logic [ADDR_WIDTH-1:0] base_q, base_n;
  logic [LEN_WIDTH-1:0]  len_q, len_n;
  logic [CNT_W-1:0]      issued_q, issued_n;
  logic [CNT_W-1:0]      returned_q, returned_n;
  logic [CNT_W-1:0]      sent_q, sent_n;
  logic                  arvalid_q, arvalid_n;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_n;
  logic                  rready_q, rready_n;
  logic                  tvalid_q, tvalid_n;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_n;
  logic                  tlast_q, tlast_n;
  logic                  busy_q, busy_n;
  logic                  done_q, done_n;
  logic                  error_q, error_n;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic ar_hs, r_hs, beat;

  assign ar_hs = arvalid_q & m_axil_arready;
  assign r_hs  = m_axil_rvalid & rready_q;
  assign beat  = tvalid_q & m_axis_tready;

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;
  assign m_axis_tdata   = tdata_q;
  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tlast   = tlast_q;

  // FIFO storage; write slot is the low bits of the returned-word count.
  always_ff @(posedge clk) begin
    if (r_hs) mem[returned_q[PTR_W-1:0]] <= m_axil_rdata;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      sent_q     <= '0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      rready_q   <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_n;
      base_q     <= base_n;
      len_q      <= len_n;
      issued_q   <= issued_n;
      returned_q <= returned_n;
      sent_q     <= sent_n;
      arvalid_q  <= arvalid_n;
      araddr_q   <= araddr_n;
      rready_q   <= rready_n;
      tvalid_q   <= tvalid_n;
      tdata_q    <= tdata_n;
      tlast_q    <= tlast_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      error_q    <= error_n;
    end
  end

  // Next-state, credit-limited address issue and FIFO head prefetch.
  always_comb begin
    state_n    = state_q;
    base_n     = base_q;
    len_n      = len_q;
    issued_n   = issued_q;
    returned_n = returned_q;
    sent_n     = sent_q;
    arvalid_n  = 1'b0;
    araddr_n   = araddr_q;
    tdata_n    = tdata_q;
    tlast_n    = 1'b0;
    error_n    = error_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_n     = base_addr & ALIGN_MASK;
          len_n      = length;
          issued_n   = '0;
          returned_n = '0;
          sent_n     = '0;
          error_n    = 1'b0;
          state_n    = (length == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        issued_n   = issued_q + CNT_W'(ar_hs);
        returned_n = returned_q + CNT_W'(r_hs);
        sent_n     = sent_q + CNT_W'(beat);
        if (r_hs && (m_axil_rresp != 2'b00)) error_n = 1'b1;
        if (beat && tlast_q) state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // A request is only raised when its response already has a FIFO slot.
    if (state_n == ST_RUN) begin
      arvalid_n = (arvalid_q && !m_axil_arready) ||
                  ((issued_n < {1'b0, len_n}) &&
                   ((issued_n - sent_n) < CNT_W'(FIFO_DEPTH)));
      araddr_n  = base_n + (ADDR_WIDTH'(issued_n) << ADDR_LSB);
    end

    rready_n = (state_n == ST_RUN);
    busy_n   = (state_n == ST_RUN);
    done_n   = (state_n == ST_DONE);

    // Occupancy is returned - sent, never more than FIFO_DEPTH.
    tvalid_n = (returned_n != sent_n);
    if (tvalid_n) begin
      // Bypass the word being written when it becomes the new head.
      if (r_hs && (returned_q[PTR_W-1:0] == sent_n[PTR_W-1:0]))
        tdata_n = m_axil_rdata;
      else
        tdata_n = mem[sent_n[PTR_W-1:0]];
      tlast_n = (sent_n == ({1'b0, len_n} - CNT_W'(1)));
    end
  end

endmodule
